// File: rtl/time_counter_if.sv
// Bus bundle for time_counter.
// Inputs:  en_1hz, set_mode, inc_min, inc_hour, clr_sec.
// Outputs: hour_bcd, min_bcd, sec_bcd (packed BCD), pm, min_tick, hour_tick, day_tick.
// The master modport drives the control inputs. The slave modport is the counter side.
interface time_counter_if;
    logic       en_1hz;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic       clr_sec;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       pm;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;

    modport master (
        output en_1hz, set_mode, inc_min, inc_hour, clr_sec,
        input  hour_bcd, min_bcd, sec_bcd, pm, min_tick, hour_tick, day_tick
    );

    modport slave (
        input  en_1hz, set_mode, inc_min, inc_hour, clr_sec,
        output hour_bcd, min_bcd, sec_bcd, pm, min_tick, hour_tick, day_tick
    );
endinterface

// File: rtl/time_counter.sv
// BCD hours/minutes/seconds timekeeper with a RUN/SET mode machine.
// Ports: clk, rst (async active-high), bus (time_counter_if.slave).
// In RUN, en_1hz advances the seconds, and carries ripple into minutes and hours with tick pulses.
// In SET, inc_min, inc_hour and clr_sec edit the fields directly. No carries and no ticks are produced in SET.
// FMT_12H=1 counts hours from 01 to 12 and keeps an AM/PM flag.
module time_counter #(
    parameter bit FMT_12H = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    time_counter_if.slave  bus
);

    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

    localparam logic [7:0] HOUR_RST  = FMT_12H ? 8'h12 : 8'h00;
    localparam logic [7:0] HOUR_LAST = FMT_12H ? 8'h11 : 8'h23;

    state_t     state_q, state_d;
    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       pm_q, pm_d;
    logic       min_tick_q, min_tick_d;
    logic       hour_tick_q, hour_tick_d;
    logic       day_tick_q, day_tick_d;
    logic [8:0] hour_nxt;
    logic       day_last;

    // Add one to a packed BCD value. A units digit of 9 rolls into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc60(input logic [7:0] v);
        return (v == 8'h59) ? 8'h00 : bcd_inc(v);
    endfunction

    // Returns {pm, hour} after one hour step in the selected format.
    function automatic logic [8:0] hour_inc(input logic [7:0] h, input logic p);
        if (FMT_12H) begin
            if (h == 8'h12) return {p, 8'h01};
            if (h == 8'h11) return {~p, 8'h12};
            return {p, bcd_inc(h)};
        end
        if (h == 8'h23) return {1'b0, 8'h00};
        return {1'b0, bcd_inc(h)};
    endfunction

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            hour_q      <= HOUR_RST;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            pm_q        <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            pm_q        <= pm_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
        end
    end

    // Next-state and field update. The registered state selects the behaviour for the current edge.
    always_comb begin
        state_d     = bus.set_mode ? SET : RUN;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        pm_d        = pm_q;
        min_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        day_tick_d  = 1'b0;
        hour_nxt    = hour_inc(hour_q, pm_q);
        // The last hour of the day is 23 in 24-hour mode, or 11 PM in 12-hour mode.
        day_last    = (hour_q == HOUR_LAST) && (FMT_12H ? pm_q : 1'b1);

        case (state_q)
            RUN: begin
                if (bus.en_1hz) begin
                    sec_d = inc60(sec_q);
                    if (sec_q == 8'h59) begin
                        min_tick_d = 1'b1;
                        min_d      = inc60(min_q);
                        if (min_q == 8'h59) begin
                            hour_tick_d    = 1'b1;
                            {pm_d, hour_d} = hour_nxt;
                            day_tick_d     = day_last;
                        end
                    end
                end
            end
            SET: begin
                if (bus.inc_min)  min_d = inc60(min_q);
                if (bus.inc_hour) {pm_d, hour_d} = hour_nxt;
                if (bus.clr_sec)  sec_d = 8'h00;
            end
        endcase
    end

    assign bus.hour_bcd  = hour_q;
    assign bus.min_bcd   = min_q;
    assign bus.sec_bcd   = sec_q;
    assign bus.pm        = pm_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hour_tick = hour_tick_q;
    assign bus.day_tick  = day_tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter.
// Runs a 24-hour instance and a 12-hour instance in lockstep on the same inputs.
// Each cycle's expected outputs come from a decimal reference model and are queued.
// The queued entry is compared once the DUTs have updated.
module tb_time_counter;

    logic clk = 1'b0;
    logic rst;
    logic en_1hz, set_mode, inc_min, inc_hour, clr_sec;

    always #5 clk = ~clk;

    time_counter_if if24();
    time_counter_if if12();

    assign if24.en_1hz   = en_1hz;
    assign if24.set_mode = set_mode;
    assign if24.inc_min  = inc_min;
    assign if24.inc_hour = inc_hour;
    assign if24.clr_sec  = clr_sec;
    assign if12.en_1hz   = en_1hz;
    assign if12.set_mode = set_mode;
    assign if12.inc_min  = inc_min;
    assign if12.inc_hour = inc_hour;
    assign if12.clr_sec  = clr_sec;

    time_counter #(.FMT_12H(1'b0)) dut24 (.clk(clk), .rst(rst), .bus(if24.slave));
    time_counter #(.FMT_12H(1'b1)) dut12 (.clk(clk), .rst(rst), .bus(if12.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state, indexed by format (0 = 24h, 1 = 12h).
    int mh[2];
    int mm[2];
    int ms[2];
    bit mpm[2];
    bit mset[2];

    typedef struct {
        logic [31:0] e24;
        logic [31:0] e12;
    } exp_t;
    exp_t sbq[$];

    int tick_cnt;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [31:0] obs24();
        return {4'h0, if24.hour_bcd, if24.min_bcd, if24.sec_bcd,
                if24.pm, if24.min_tick, if24.hour_tick, if24.day_tick};
    endfunction

    function automatic logic [31:0] obs12();
        return {4'h0, if12.hour_bcd, if12.min_bcd, if12.sec_bcd,
                if12.pm, if12.min_tick, if12.hour_tick, if12.day_tick};
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 2; f++) begin
            mh[f] = (f == 1) ? 12 : 0;
            mm[f] = 0;
            ms[f] = 0;
            mpm[f] = 1'b0;
            mset[f] = 1'b0;
        end
    endtask

    task automatic hour_adv(input int f, output bit day);
        day = 1'b0;
        if (f == 0) begin
            mh[f] = (mh[f] + 1) % 24;
            day = (mh[f] == 0);
        end else if (mh[f] == 11) begin
            mh[f] = 12;
            mpm[f] = !mpm[f];
            day = !mpm[f];
        end else if (mh[f] == 12) begin
            mh[f] = 1;
        end else begin
            mh[f] = mh[f] + 1;
        end
    endtask

    task automatic model_step(input int f, output logic [31:0] e);
        bit mt, ht, dt, dummy;
        mt = 0; ht = 0; dt = 0;
        if (!mset[f]) begin
            if (en_1hz) begin
                ms[f]++;
                if (ms[f] == 60) begin
                    ms[f] = 0; mt = 1; mm[f]++;
                    if (mm[f] == 60) begin
                        mm[f] = 0; ht = 1;
                        hour_adv(f, dt);
                    end
                end
            end
        end else begin
            if (inc_min)  mm[f] = (mm[f] + 1) % 60;
            if (inc_hour) hour_adv(f, dummy);
            if (clr_sec)  ms[f] = 0;
        end
        mset[f] = set_mode;
        e = {4'h0, to_bcd(mh[f]), to_bcd(mm[f]), to_bcd(ms[f]), mpm[f], mt, ht, dt};
    endtask

    // Runs one clock with the given pulse inputs, then checks the cycle's result against the scoreboard.
    task automatic cycle(input string tag, input bit en, input bit im, input bit ih, input bit cs);
        exp_t e;
        @(negedge clk);
        en_1hz = en; inc_min = im; inc_hour = ih; clr_sec = cs;
        model_step(0, e.e24);
        model_step(1, e.e12);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({tag, "/24h"}, obs24(), e.e24);
        check({tag, "/12h"}, obs12(), e.e12);
        if (if24.min_tick) tick_cnt++;
    endtask

    // A pulse followed by an idle cycle, so that en_1hz is never high on two consecutive edges.
    task automatic pulse(input string tag, input bit en, input bit im, input bit ih, input bit cs);
        cycle(tag, en, im, ih, cs);
        cycle({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between clock edges and checks that it acts before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check({tag, "_async24"}, obs24(), 32'h0000_0000);
        check({tag, "_async12"}, obs12(), 32'h0120_0000);
        set_mode = 1'b0; en_1hz = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; clr_sec = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int tick_at;
        rst = 1'b1;
        set_mode = 1'b0; en_1hz = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; clr_sec = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset, then 61 seconds of counting
        do_reset("t1");
        tick_cnt = 0;
        tick_at = 0;
        for (int i = 1; i <= 61; i++) begin
            cycle("t1_en", 1'b1, 1'b0, 1'b0, 1'b0);
            if (if24.min_tick) tick_at = i;
            cycle("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("t1_sec", 32'(if24.sec_bcd), 32'h01);
        check("t1_min", 32'(if24.min_bcd), 32'h01);
        check("t1_tick_cnt", 32'(tick_cnt), 32'd1);
        check("t1_tick_at", 32'(tick_at), 32'd60);

        // 24-hour rollover from 23:59:59
        do_reset("t2");
        set_mode = 1'b1;
        cycle("t2_enter", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) pulse("t2_hr", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) pulse("t2_mn", 1'b0, 1'b1, 1'b0, 1'b0);
        set_mode = 1'b0;
        cycle("t2_exit", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) pulse("t2_sec", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_pre", obs24(), {4'h0, 8'h23, 8'h59, 8'h59, 4'b0000});
        cycle("t2_roll", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_rollover", obs24(), {4'h0, 8'h00, 8'h00, 8'h00, 4'b0111});
        cycle("t2_after", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_ticks_clear", 32'({if24.min_tick, if24.hour_tick, if24.day_tick}), 32'h0);

        // 12-hour format stepping in SET
        do_reset("t3");
        check("t3_rst", 32'({if12.hour_bcd, if12.pm}), 32'({8'h12, 1'b0}));
        set_mode = 1'b1;
        cycle("t3_enter", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) pulse("t3_hr", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_h11", 32'({if12.hour_bcd, if12.pm}), 32'({8'h11, 1'b0}));
        pulse("t3_hr12", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_h12pm", 32'({if12.hour_bcd, if12.pm}), 32'({8'h12, 1'b1}));
        pulse("t3_hr01", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_h01pm", 32'({if12.hour_bcd, if12.pm}), 32'({8'h01, 1'b1}));

        // SET isolation at 00:59:30
        do_reset("t4");
        set_mode = 1'b1;
        cycle("t4_enter", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) pulse("t4_mn", 1'b0, 1'b1, 1'b0, 1'b0);
        set_mode = 1'b0;
        cycle("t4_exit", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) pulse("t4_sec", 1'b1, 1'b0, 1'b0, 1'b0);
        set_mode = 1'b1;
        cycle("t4_enter2", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t4_min_en", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_isolate", obs24(), {4'h0, 8'h00, 8'h00, 8'h30, 4'b0000});
        cycle("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t4_clr", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_clr_sec", 32'(if24.sec_bcd), 32'h00);

        // Simultaneous events
        do_reset("t5");
        for (int i = 0; i < 9; i++) pulse("t5_sec", 1'b1, 1'b0, 1'b0, 1'b0);
        set_mode = 1'b1;
        cycle("t5_edge", 1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_sec10", 32'(if24.sec_bcd), 32'h10);
        check("t5_edge_ignored", 32'({if24.hour_bcd, if24.min_bcd}), 32'h0000);
        cycle("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("t5_both", 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_both24", 32'({if24.hour_bcd, if24.min_bcd}), 32'h0101);
        check("t5_both12", 32'({if12.hour_bcd, if12.min_bcd}), 32'h0101);

        // Asynchronous reset in SET at 14:27:45
        do_reset("t6_pre");
        set_mode = 1'b1;
        cycle("t6_enter", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) pulse("t6_hr", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 27; i++) pulse("t6_mn", 1'b0, 1'b1, 1'b0, 1'b0);
        set_mode = 1'b0;
        cycle("t6_exit", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 45; i++) pulse("t6_sec", 1'b1, 1'b0, 1'b0, 1'b0);
        set_mode = 1'b1;
        cycle("t6_enter2", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_pre", obs24(), {4'h0, 8'h14, 8'h27, 8'h45, 4'b0000});
        do_reset("t6");
        cycle("t6_run", 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_run_sec", 32'(if24.sec_bcd), 32'h01);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_counter.md
# time_counter

Timekeeping core of the clock system. Consumes the one-cycle 1 Hz enable pulse from the enable timer and maintains hours, minutes and seconds as packed BCD. Provides a set mode for adjusting the time from debounced push-button pulses, plus carry pulses for downstream alarm and display logic. All state is clocked by the system clock; `en_1hz` is the only timebase.

## Interface
- `FMT_12H`, default 0: 0 selects a 24-hour count (00–23). 1 selects a 12-hour count (01–12) with an AM/PM flag.

- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `en_1hz`  in  1  single-cycle pulse, once per second, from the enable timer.
- `set_mode`  in  1  level; high selects time-set mode.
- `inc_min`  in  1  single-cycle pulse; increments minutes in set mode.
- `inc_hour`  in  1  single-cycle pulse; increments hours in set mode.
- `clr_sec`  in  1  single-cycle pulse; zeroes seconds in set mode.
- `hour_bcd`  out  8  hours, as tens[7:4] and units[3:0].
- `min_bcd`  out  8  minutes, packed BCD.
- `sec_bcd`  out  8  seconds, packed BCD.
- `pm`  out  1  PM flag; constant 0 when FMT_12H=0.
- `min_tick`  out  1  one-cycle pulse when seconds wrap 59→00 in RUN.
- `hour_tick`  out  1  one-cycle pulse when minutes wrap 59→00 in RUN.
- `day_tick`  out  1  one-cycle pulse at the day rollover in RUN.

## Operation
- **State machine:** two states, RUN and SET, held in a state register.
  - RUN→SET on the first clock edge where `set_mode`=1.
  - SET→RUN on the first clock edge where `set_mode`=0.
  - The state sampled at an edge governs that edge's update.
- **RUN:**
  - On an edge with `en_1hz`=1, seconds increment.
  - Seconds 59→00 carries into minutes.
  - Minutes 59→00 carries into hours.
  - `inc_min`, `inc_hour` and `clr_sec` are ignored.
- **SET:**
  - `en_1hz` is ignored; seconds are frozen.
  - `inc_min` increments minutes with wrap 59→00 and no carry into hours.
  - `inc_hour` increments hours with format wrap; no carry, and no tick pulses.
  - `clr_sec` loads seconds with 00.
  - Any combination of these three inputs asserted on the same edge is applied together.
- **BCD arithmetic:**
  - Units digit 9→0 increments the tens digit.
  - Digits never leave the range 0–9; tens of sec/min never exceeds 5.
  - No binary-to-BCD conversion is used; counters are BCD-native.
- **Hours, 24h:** 23→00.
- **Hours, 12h:**
  - 11→12 toggles `pm`.
  - 12→01 leaves `pm` unchanged.
  - Hours never reach 00.
  - In SET, `inc_hour` across 11→12 also toggles `pm`.
- **Day rollover:**
  - 24h: 23:59:59→00:00:00.
  - 12h: 11:59:59 PM→12:00:00 AM.
  - A rollover raises `min_tick`, `hour_tick` and `day_tick` together.

## Timing
- **Reset values:**
  - `sec_bcd`=8'h00, `min_bcd`=8'h00, `pm`=0, all ticks 0, state RUN.
  - `hour_bcd`=8'h00 when FMT_12H=0, 8'h12 when FMT_12H=1.
  - Reset takes effect immediately and asynchronously, mid-count or mid-set; counting resumes on the first `en_1hz` after release.
- **Latency:** all outputs are registered. An update sampled at edge N is visible after edge N, with one cycle of latency from the input pulse.
- **Tick pulses:** registered and coincident with the counter update that caused them. Each is exactly one cycle wide, since `en_1hz` is never high on consecutive cycles.
- **Mode changes:**
  - `en_1hz` on the same edge where `set_mode` first rises is still counted (state is RUN).
  - A set pulse on the same edge where `set_mode` first rises is ignored.
  - An `en_1hz` pulse that arrives while in SET is lost; there is no catch-up.
- **Outputs in SET:** outputs reflect edits in real time; no ticks are generated.

## Test plan
- **Reset and count:** assert `rst` with FMT_12H=0, release, apply 61 `en_1hz` pulses → `sec_bcd`=8'h01, `min_bcd`=8'h01, exactly one `min_tick` pulse, on the 60th pulse.
- **24h rollover:** preload 23:59:59 via SET (23×`inc_hour`, 59×`inc_min`, then 59 RUN seconds), apply one `en_1hz` → 00:00:00, with `min_tick`, `hour_tick` and `day_tick` all high for one cycle.
- **12h format:** FMT_12H=1, reset → 12:00:00 with `pm`=0. Step hours in SET 11 times → 11, `pm`=0. One more step → 12, `pm`=1. One more → 01, `pm`=1.
- **Set mode isolation:** in SET at 00:59:30, apply `inc_min` and `en_1hz` → 00:00:30, hour unchanged, `sec_bcd` still 8'h30, no ticks. Then `clr_sec` → `sec_bcd`=8'h00.
- **Simultaneous events:** raise `set_mode` on the same cycle as `en_1hz` at sec 8'h09 → 8'h10 is counted. Apply `inc_min` and `inc_hour` together in SET → both fields advance by 1.
- **Reset mid-operation:** assert `rst` asynchronously between clock edges in SET at 14:27:45 → outputs read 00:00:00 before the next edge and the state is RUN after release.
